// File: rtl/load_store_unit_if.sv
// Word-wide valid/ready memory port between the load/store unit and the data memory.
// The master drives the request; the slave answers with ready and read data in the same cycle.
interface load_store_unit_if;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic [31:0] mem_rdata;

   modport master (
      output mem_valid,
      output mem_addr,
      output mem_wdata,
      output mem_wmask,
      input  mem_ready,
      input  mem_rdata
   );

   modport slave (
      input  mem_valid,
      input  mem_addr,
      input  mem_wdata,
      input  mem_wmask,
      output mem_ready,
      output mem_rdata
   );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage of the rv32im multicycle core: aligns stores onto byte lanes,
// extracts and extends loads, and flags misaligned, illegal or timed-out accesses.
module load_store_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic        busy,
   output logic        done,
   output logic        fault,
   output logic [31:0] load_data,
   load_store_unit_if.master mem
);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   state_t      state;
   state_t      next_state;
   logic [2:0]  req_funct3;
   logic [1:0]  req_offset;
   logic        fault_pending;
   logic [31:0] timeout_count;
   logic [31:0] addr_reg;
   logic [31:0] wdata_reg;
   logic [3:0]  wmask_reg;
   logic        request_ok;
   logic        handshake;
   logic        timed_out;
   logic [31:0] lane_wdata;
   logic [3:0]  lane_wmask;
   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic [31:0] extracted;

   function automatic logic funct3_legal(input logic st, input logic [2:0] f3);
      case (f3)
         3'b000, 3'b001, 3'b010: return 1'b1;
         3'b100, 3'b101:         return !st;
         default:                return 1'b0;
      endcase
   endfunction

   function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] offset);
      case (f3[1:0])
         2'b01:   return offset[0] == 1'b0;
         2'b10:   return offset == 2'b00;
         default: return 1'b1;
      endcase
   endfunction

   always_comb begin
      request_ok = funct3_legal(is_store, funct3) && is_aligned(funct3, addr[1:0]);
   end

   // Store data replicated across every lane it could occupy; the mask selects the live bytes.
   always_comb begin
      lane_wdata = store_data;
      lane_wmask = 4'b1111;
      case (funct3[1:0])
         2'b00: begin
            lane_wdata = {4{store_data[7:0]}};
            lane_wmask = 4'b0001 << addr[1:0];
         end
         2'b01: begin
            lane_wdata = {2{store_data[15:0]}};
            lane_wmask = addr[1] ? 4'b1100 : 4'b0011;
         end
         default: ;
      endcase
   end

   always_comb begin
      byte_lane = 8'(mem.mem_rdata >> {req_offset, 3'b000});
      half_lane = 16'(mem.mem_rdata >> {req_offset[1], 4'b0000});
      case (req_funct3)
         3'b000:  extracted = {{24{byte_lane[7]}}, byte_lane};
         3'b001:  extracted = {{16{half_lane[15]}}, half_lane};
         3'b010:  extracted = mem.mem_rdata;
         3'b100:  extracted = {24'd0, byte_lane};
         3'b101:  extracted = {16'd0, half_lane};
         default: extracted = 32'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Ready in the last allowed REQ cycle takes priority over the timeout abort.
   always_comb begin
      next_state = state;
      handshake  = 1'b0;
      timed_out  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               next_state = request_ok ? REQ : RESP;
            end
         end
         REQ: begin
            if (mem.mem_ready) begin
               handshake  = 1'b1;
               next_state = RESP;
            end else if (TIMEOUT_CYCLES != 0 && timeout_count == TIMEOUT_CYCLES - 1) begin
               timed_out  = 1'b1;
               next_state = RESP;
            end
         end
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         req_funct3    <= 3'd0;
         req_offset    <= 2'd0;
         fault_pending <= 1'b0;
         timeout_count <= 32'd0;
         addr_reg      <= 32'd0;
         wdata_reg     <= 32'd0;
         wmask_reg     <= 4'd0;
         load_data     <= 32'd0;
      end else begin
         if (state == IDLE && start) begin
            req_funct3    <= funct3;
            req_offset    <= addr[1:0];
            fault_pending <= !request_ok;
            timeout_count <= 32'd0;
            load_data     <= 32'd0;
            addr_reg      <= {addr[31:2], 2'b00};
            wdata_reg     <= is_store ? lane_wdata : 32'd0;
            wmask_reg     <= (is_store && request_ok) ? lane_wmask : 4'b0000;
         end
         if (state == REQ) begin
            if (handshake) begin
               if (wmask_reg == 4'b0000) begin
                  load_data <= extracted;
               end
            end else begin
               timeout_count <= timeout_count + 32'd1;
            end
            if (timed_out) begin
               fault_pending <= 1'b1;
            end
         end
      end
   end

   assign busy          = (state != IDLE);
   assign done          = (state == RESP);
   assign fault         = (state == RESP) && fault_pending;
   assign mem.mem_valid = (state == REQ);
   assign mem.mem_addr  = addr_reg;
   assign mem.mem_wdata = wdata_reg;
   assign mem.mem_wmask = wmask_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a four-cycle bus timeout.
// Each scenario task drives its stimulus and compares against hand-computed values.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        is_store;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] store_data;
   logic        busy;
   logic        done;
   logic        fault;
   logic [31:0] load_data;
   int          tests_run = 0;
   int          tests_failed = 0;

   load_store_unit_if mem_bus ();

   load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .is_store   (is_store),
      .funct3     (funct3),
      .addr       (addr),
      .store_data (store_data),
      .busy       (busy),
      .done       (done),
      .fault      (fault),
      .load_data  (load_data),
      .mem        (mem_bus)
   );

   always #5 clk = ~clk;

   localparam logic [2:0]  ST_F3    [5] = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b010};
   localparam logic [31:0] ST_ADDR  [5] = '{32'h1003, 32'h1001, 32'h1002, 32'h1000, 32'h1004};
   localparam logic [31:0] ST_DATA  [5] = '{32'h000000A5, 32'h12345637, 32'h12345678, 32'hCAFEBEEF, 32'hDEADBEEF};
   localparam logic [31:0] ST_WDATA [5] = '{32'hA5A5A5A5, 32'h37373737, 32'h56785678, 32'hBEEFBEEF, 32'hDEADBEEF};
   localparam logic [3:0]  ST_WMASK [5] = '{4'b1000, 4'b0010, 4'b1100, 4'b0011, 4'b1111};

   localparam logic [2:0]  LD_F3    [6] = '{3'b001, 3'b101, 3'b010, 3'b000, 3'b100, 3'b001};
   localparam logic [31:0] LD_ADDR  [6] = '{32'h2000, 32'h2002, 32'h2004, 32'h2003, 32'h2000, 32'h2002};
   localparam logic [31:0] LD_RDATA [6] = '{32'h00008001, 32'hBEEF1234, 32'h12345678, 32'h7F000000, 32'h000000F0, 32'h80000000};
   localparam logic [31:0] LD_EXP   [6] = '{32'hFFFF8001, 32'h0000BEEF, 32'h12345678, 32'h0000007F, 32'h000000F0, 32'hFFFF8000};

   localparam logic        FT_ST    [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
   localparam logic [2:0]  FT_F3    [5] = '{3'b010, 3'b011, 3'b001, 3'b100, 3'b010};
   localparam logic [31:0] FT_ADDR  [5] = '{32'h3002, 32'h3000, 32'h3001, 32'h3000, 32'h3001};

   // Presents one request for a single clock; returns at the falling edge after acceptance.
   task automatic applyStimulus(input logic st, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      is_store   = st;
      funct3     = f3;
      addr       = a;
      store_data = d;
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b1;
      is_store = 1'b0;
      funct3 = 3'b010;
      addr = 32'h10;
      store_data = 32'h0;
      mem_bus.mem_ready = 1'b1;
      mem_bus.mem_rdata = 32'h0;
      repeat (2) @(negedge clk);
      tests_run++;
      if (busy !== 1'b0 || mem_bus.mem_valid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_hold: busy=%b mem_valid=%b expected 0 0", busy, mem_bus.mem_valid);
      end
      reset = 1'b0;
      start = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({busy, done, fault, mem_bus.mem_valid} !== 4'b0000) begin
         tests_failed++;
         $display("[TB] FAIL reset_flags: busy/done/fault/valid=%b expected 0000",
                  {busy, done, fault, mem_bus.mem_valid});
      end
      tests_run++;
      if (load_data !== 32'h0 || mem_bus.mem_addr !== 32'h0 ||
          mem_bus.mem_wdata !== 32'h0 || mem_bus.mem_wmask !== 4'h0) begin
         tests_failed++;
         $display("[TB] FAIL reset_data: load=%h addr=%h wdata=%h wmask=%b expected all 0",
                  load_data, mem_bus.mem_addr, mem_bus.mem_wdata, mem_bus.mem_wmask);
      end
   endtask

   task automatic test_store_lanes();
      mem_bus.mem_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, ST_F3[i], ST_ADDR[i], ST_DATA[i]);
         tests_run++;
         if (mem_bus.mem_valid !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL store_req[%0d]: valid=%b done=%b busy=%b expected 1 0 1",
                     i, mem_bus.mem_valid, done, busy);
         end
         tests_run++;
         if (mem_bus.mem_addr !== (ST_ADDR[i] & 32'hFFFF_FFFC)) begin
            tests_failed++;
            $display("[TB] FAIL store_addr[%0d]: got %h expected %h", i, mem_bus.mem_addr,
                     ST_ADDR[i] & 32'hFFFF_FFFC);
         end
         tests_run++;
         if (mem_bus.mem_wdata !== ST_WDATA[i] || mem_bus.mem_wmask !== ST_WMASK[i]) begin
            tests_failed++;
            $display("[TB] FAIL store_lanes[%0d]: wdata=%h wmask=%b expected %h %b", i,
                     mem_bus.mem_wdata, mem_bus.mem_wmask, ST_WDATA[i], ST_WMASK[i]);
         end
         @(negedge clk);
         tests_run++;
         if (done !== 1'b1 || fault !== 1'b0 || mem_bus.mem_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL store_done[%0d]: done=%b fault=%b valid=%b expected 1 0 0",
                     i, done, fault, mem_bus.mem_valid);
         end
      end
   endtask

   task automatic test_load_extend();
      mem_bus.mem_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         mem_bus.mem_rdata = LD_RDATA[i];
         applyStimulus(1'b0, LD_F3[i], LD_ADDR[i], 32'hFFFF_FFFF);
         tests_run++;
         if (mem_bus.mem_valid !== 1'b1 || mem_bus.mem_wmask !== 4'b0000 ||
             mem_bus.mem_addr !== (LD_ADDR[i] & 32'hFFFF_FFFC)) begin
            tests_failed++;
            $display("[TB] FAIL load_req[%0d]: valid=%b wmask=%b addr=%h expected 1 0000 %h", i,
                     mem_bus.mem_valid, mem_bus.mem_wmask, mem_bus.mem_addr,
                     LD_ADDR[i] & 32'hFFFF_FFFC);
         end
         @(negedge clk);
         tests_run++;
         if (done !== 1'b1 || fault !== 1'b0 || load_data !== LD_EXP[i]) begin
            tests_failed++;
            $display("[TB] FAIL load_data[%0d]: done=%b fault=%b data=%h expected 1 0 %h",
                     i, done, fault, load_data, LD_EXP[i]);
         end
      end
   endtask

   task automatic test_load_stall();
      mem_bus.mem_rdata = 32'h000080FF;
      for (int i = 0; i < 2; i++) begin
         mem_bus.mem_ready = 1'b0;
         applyStimulus(1'b0, (i == 0) ? 3'b000 : 3'b100, 32'h2001, 32'h0);
         repeat (3) @(negedge clk);
         tests_run++;
         if (mem_bus.mem_valid !== 1'b1 || done !== 1'b0 || mem_bus.mem_addr !== 32'h2000) begin
            tests_failed++;
            $display("[TB] FAIL stall_hold[%0d]: valid=%b done=%b addr=%h expected 1 0 00002000",
                     i, mem_bus.mem_valid, done, mem_bus.mem_addr);
         end
         mem_bus.mem_ready = 1'b1;
         @(negedge clk);
         tests_run++;
         if (done !== 1'b1 || fault !== 1'b0 ||
             load_data !== ((i == 0) ? 32'hFFFFFF80 : 32'h00000080)) begin
            tests_failed++;
            $display("[TB] FAIL stall_data[%0d]: done=%b fault=%b data=%h expected 1 0 %h", i,
                     done, fault, load_data, (i == 0) ? 32'hFFFFFF80 : 32'h00000080);
         end
      end
   endtask

   task automatic test_faults();
      mem_bus.mem_ready = 1'b1;
      mem_bus.mem_rdata = 32'h5555_5555;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(FT_ST[i], FT_F3[i], FT_ADDR[i], 32'h1234_5678);
         tests_run++;
         if (done !== 1'b1 || fault !== 1'b1 || mem_bus.mem_valid !== 1'b0 || load_data !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL fault_resp[%0d]: done=%b fault=%b valid=%b data=%h expected 1 1 0 0",
                     i, done, fault, mem_bus.mem_valid, load_data);
         end
         @(negedge clk);
         tests_run++;
         if (busy !== 1'b0 || mem_bus.mem_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL fault_idle[%0d]: busy=%b valid=%b expected 0 0",
                     i, busy, mem_bus.mem_valid);
         end
      end
   endtask

   task automatic test_timeout();
      int valid_cycles;
      int waited;
      mem_bus.mem_ready = 1'b0;
      mem_bus.mem_rdata = 32'hAAAA_AAAA;
      applyStimulus(1'b0, 3'b010, 32'h4000, 32'h0);
      valid_cycles = 0;
      waited = 0;
      while (done !== 1'b1 && waited < 20) begin
         if (mem_bus.mem_valid === 1'b1) valid_cycles++;
         @(negedge clk);
         waited++;
      end
      tests_run++;
      if (done !== 1'b1 || valid_cycles != 4) begin
         tests_failed++;
         $display("[TB] FAIL timeout_len: done=%b valid_cycles=%0d expected 1 4", done, valid_cycles);
      end
      tests_run++;
      if (fault !== 1'b1 || load_data !== 32'h0 || mem_bus.mem_valid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL timeout_fault: fault=%b data=%h valid=%b expected 1 0 0",
                  fault, load_data, mem_bus.mem_valid);
      end
      applyStimulus(1'b1, 3'b010, 32'h4004, 32'h0F0F_0F0F);
      repeat (3) @(negedge clk);
      mem_bus.mem_ready = 1'b1;
      @(negedge clk);
      tests_run++;
      if (done !== 1'b1 || fault !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL timeout_ready_wins: done=%b fault=%b expected 1 0", done, fault);
      end
   endtask

   task automatic test_reset_midflight();
      int dones;
      mem_bus.mem_ready = 1'b0;
      applyStimulus(1'b0, 3'b010, 32'h5000, 32'h0);
      tests_run++;
      if (mem_bus.mem_valid !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL midflight_req: valid=%b expected 1", mem_bus.mem_valid);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      tests_run++;
      if (mem_bus.mem_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL midflight_abort: valid=%b busy=%b done=%b expected 0 0 0",
                  mem_bus.mem_valid, busy, done);
      end
      dones = 0;
      repeat (8) begin
         @(negedge clk);
         if (done === 1'b1) dones++;
      end
      tests_run++;
      if (dones != 0) begin
         tests_failed++;
         $display("[TB] FAIL midflight_done: got %0d done pulses expected 0", dones);
      end
   endtask

   task automatic test_start_while_busy();
      int dones;
      logic [31:0] captured;
      mem_bus.mem_ready = 1'b0;
      mem_bus.mem_rdata = 32'h0BAD_F00D;
      applyStimulus(1'b0, 3'b010, 32'h6000, 32'h0);
      is_store   = 1'b1;
      funct3     = 3'b010;
      addr       = 32'h7000;
      store_data = 32'h1111_2222;
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
      tests_run++;
      if (mem_bus.mem_addr !== 32'h6000 || mem_bus.mem_wmask !== 4'b0000 || mem_bus.mem_valid !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL busy_ignore: addr=%h wmask=%b valid=%b expected 00006000 0000 1",
                  mem_bus.mem_addr, mem_bus.mem_wmask, mem_bus.mem_valid);
      end
      mem_bus.mem_ready = 1'b1;
      dones = 0;
      captured = 32'h0;
      repeat (8) begin
         @(negedge clk);
         if (done === 1'b1) begin
            dones++;
            captured = load_data;
         end
      end
      tests_run++;
      if (dones != 1 || captured !== 32'h0BAD_F00D) begin
         tests_failed++;
         $display("[TB] FAIL busy_single_done: dones=%0d data=%h expected 1 0badf00d", dones, captured);
      end
   endtask

   initial begin
      test_reset();
      test_store_lanes();
      test_load_extend();
      test_load_stall();
      test_faults();
      test_timeout();
      test_reset_midflight();
      test_start_while_busy();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
